// File: rtl/sort8_pkg.sv
// rtl/sort8_pkg.sv - shared types and helpers for the sort8_ctrl batch sorter
// Contents:
//   WORD_W  - width of a sorted word
//   state_e - controller phase (load batch, bubble-sort, drain sorted words)
//   idx_w() - index width for a buffer of a given depth (ceil(log2), minimum 1)
package sort8_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Elaboration-time helper; depth is limited to 2..16 so five steps suffice.
  function automatic int idx_w(input int depth);
    int w;
    w = 1;
    for (int n = 0; n < 5; n++) begin
      if ((1 << w) < depth) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ge8_cmp.sv
// rtl/ge8_cmp.sv - combinational unsigned 8-bit a >= b built from 2-bit slices
// Ports:
//   a_i  in  8  left operand
//   b_i  in  8  right operand
//   ge_o out 1  a_i >= b_i (unsigned)
module ge8_cmp
  import sort8_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic              ge_o
);

  logic [3:0] gt;
  logic [3:0] eq;
  logic       acc;

  for (genvar k = 0; k < 4; k++) begin : g_slice
    assign gt[k] = (a_i[2*k+1] & ~b_i[2*k+1]) |
                   (~(a_i[2*k+1] ^ b_i[2*k+1]) & a_i[2*k] & ~b_i[2*k]);
    assign eq[k] = ~(a_i[2*k+1] ^ b_i[2*k+1]) & ~(a_i[2*k] ^ b_i[2*k]);
  end

  // Ripple from LSB slice upward: a fully equal word counts as ">=", and each
  // higher slice overrides the verdict unless it is equal.
  always_comb begin
    acc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      acc = gt[k] | (eq[k] & acc);
    end
    ge_o = acc;
  end

endmodule

// File: rtl/sort8_ctrl.sv
// rtl/sort8_ctrl.sv - buffers DEPTH words, bubble-sorts them with one comparator, streams them out
// Ports:
//   clk       in  1  rising-edge clock
//   rst_n     in  1  asynchronous active-low reset
//   abort     in  1  synchronous batch cancel, back to LOAD
//   in_valid  in  1  producer word valid
//   in_ready  out 1  word accepted this cycle (LOAD only)
//   in_data   in  8  unsigned input word
//   out_valid out 1  sorted word available (DRAIN)
//   out_ready in  1  consumer accepts word
//   out_data  out 8  sorted word, ascending
//   busy      out 1  high while sorting
//   last      out 1  final output beat of the batch
module sort8_ctrl
  import sort8_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              busy,
  output logic              last
);

  localparam int            IW       = idx_w(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] END_IDX  = IW'(DEPTH - 2);

  state_e            state_q;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [IW-1:0]     wr_idx_q;
  logic [IW-1:0]     rd_idx_q;
  logic [IW-1:0]     i_q;
  logic [IW-1:0]     pass_q;
  logic              swap_q;
  // Holds in_ready low through reset and for the first edge after release.
  logic              arm_q;

  logic [IW-1:0]     i_nx;
  logic [WORD_W-1:0] lo_w;
  logic [WORD_W-1:0] hi_w;
  logic              in_order;
  logic              swap_now;

  assign i_nx     = i_q + 1'b1;
  assign lo_w     = mem_q[i_q];
  assign hi_w     = mem_q[i_nx];
  assign swap_now = ~in_order;

  // Single shared comparator: mem[i+1] >= mem[i] keeps equal words in place.
  ge8_cmp u_cmp (
    .a_i  (hi_w),
    .b_i  (lo_w),
    .ge_o (in_order)
  );

  assign in_ready  = arm_q && (state_q == ST_LOAD);
  assign busy      = (state_q == ST_SORT);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = out_valid ? mem_q[rd_idx_q] : '0;
  assign last      = out_valid && (rd_idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      arm_q    <= 1'b0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      i_q      <= '0;
      pass_q   <= '0;
      swap_q   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      arm_q <= 1'b1;
      if (abort) begin
        state_q  <= ST_LOAD;
        wr_idx_q <= '0;
        rd_idx_q <= '0;
        i_q      <= '0;
        pass_q   <= '0;
        swap_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            if (in_valid && in_ready) begin
              mem_q[wr_idx_q] <= in_data;
              if (wr_idx_q == LAST_IDX) begin
                wr_idx_q <= '0;
                state_q  <= ST_SORT;
              end else begin
                wr_idx_q <= wr_idx_q + 1'b1;
              end
            end
          end
          ST_SORT: begin
            if (swap_now) begin
              mem_q[i_q]  <= hi_w;
              mem_q[i_nx] <= lo_w;
            end
            if (i_q == END_IDX) begin
              // Pass boundary: the final compare's swap counts toward this pass.
              i_q    <= '0;
              swap_q <= 1'b0;
              if (!(swap_q || swap_now) || pass_q == END_IDX) begin
                pass_q  <= '0;
                state_q <= ST_DRAIN;
              end else begin
                pass_q <= pass_q + 1'b1;
              end
            end else begin
              i_q    <= i_nx;
              swap_q <= swap_q | swap_now;
            end
          end
          ST_DRAIN: begin
            if (out_ready) begin
              if (rd_idx_q == LAST_IDX) begin
                rd_idx_q <= '0;
                state_q  <= ST_LOAD;
              end else begin
                rd_idx_q <= rd_idx_q + 1'b1;
              end
            end
          end
          default: state_q <= ST_LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sort8_ctrl.sv
// tb/tb_sort8_ctrl.sv - self-checking bench for sort8_ctrl (DEPTH=8 and DEPTH=2)
module tb_sort8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       last;

  logic       d2_abort;
  logic       d2_in_valid;
  logic       d2_in_ready;
  logic [7:0] d2_in_data;
  logic       d2_out_valid;
  logic       d2_out_ready;
  logic [7:0] d2_out_data;
  logic       d2_busy;
  logic       d2_last;

  always #5 clk = ~clk;

  sort8_ctrl #(.DEPTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .last      (last)
  );

  sort8_ctrl #(.DEPTH(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (d2_abort),
    .in_valid  (d2_in_valid),
    .in_ready  (d2_in_ready),
    .in_data   (d2_in_data),
    .out_valid (d2_out_valid),
    .out_ready (d2_out_ready),
    .out_data  (d2_out_data),
    .busy      (d2_busy),
    .last      (d2_last)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] vec[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output scoreboard for the DEPTH=8 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          check("out_data", out_data, exp_q[0]);
          check("last", last, exp_q.size() == 1);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("last_idle", last, 32'd0);
      end
    end
  end

  // Reference: ascending order by value scan; bubble passes = largest count of
  // strictly-greater words ahead of any word, plus one clean pass, capped at 7.
  task automatic model(output int busy_exp);
    int k;
    int c;
    k = 0;
    for (int j = 0; j < 8; j++) begin
      c = 0;
      for (int i = 0; i < j; i++) if (vec[i] > vec[j]) c++;
      if (c > k) k = c;
    end
    busy_exp = ((k + 1 < 7) ? k + 1 : 7) * 7;
    for (int v = 0; v < 256; v++)
      for (int j = 0; j < 8; j++)
        if (vec[j] == 8'(v)) exp_q.push_back(vec[j]);
  endtask

  task automatic load_words(input int n, input bit junk);
    int g;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = vec[k];
      g = 0;
      @(negedge clk);
      while (!in_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (!in_ready) check("load_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = junk;
    in_data  = 8'hAA;
  endtask

  task automatic wait_sort(output int cnt);
    int g;
    g   = 0;
    cnt = 0;
    @(negedge clk);
    check("busy_first_cycle", busy, 32'd1);
    check("in_ready_in_sort", in_ready, 32'd0);
    while (!out_valid && g < 100) begin
      if (busy) cnt++;
      @(negedge clk);
      g++;
    end
    if (!out_valid) check("sort_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input bit rnd);
    int g;
    g = 0;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0 && g < 200) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      g++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (exp_q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("in_ready_after_drain", in_ready, 32'd1);
    check("out_valid_after_drain", out_valid, 32'd0);
  endtask

  task automatic run_batch(input bit junk, input bit rnd, input int lit_busy);
    int be;
    int cnt;
    load_words(8, junk);
    model(be);
    wait_sort(cnt);
    check("busy_cycles_model", cnt, be);
    if (lit_busy >= 0) check("busy_cycles_literal", cnt, lit_busy);
    drain(rnd);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] dup_in  [8] = '{8'hFF, 8'h00, 8'h80, 8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00};
  logic [7:0] dup_exp [8] = '{8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int be;
    int cnt;
    rst_n        = 1'b0;
    abort        = 1'b0;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    out_ready    = 1'b0;
    d2_abort     = 1'b0;
    d2_in_valid  = 1'b0;
    d2_in_data   = 8'h00;
    d2_out_ready = 1'b0;

    #1;
    check("rst_in_ready", in_ready, 32'd0);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_last", last, 32'd0);
    check("rst_d2_in_ready", d2_in_ready, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 32'd1);

    // DEPTH=2: load 5,3 -> one swapping compare, output 3 then 5.
    d2_in_valid = 1'b1;
    d2_in_data  = 8'd5;
    @(posedge clk);
    #1;
    d2_in_data  = 8'd3;
    @(posedge clk);
    #1;
    d2_in_valid = 1'b0;
    @(negedge clk);
    check("d2_busy_first", d2_busy, 32'd1);
    @(negedge clk);
    check("d2_busy_done", d2_busy, 32'd0);
    check("d2_valid", d2_out_valid, 32'd1);
    check("d2_data0", d2_out_data, 32'd3);
    check("d2_last0", d2_last, 32'd0);
    @(posedge clk);
    #1;
    d2_out_ready = 1'b1;
    @(negedge clk);
    check("d2_data0_held", d2_out_data, 32'd3);
    @(negedge clk);
    check("d2_data1", d2_out_data, 32'd5);
    check("d2_last1", d2_last, 32'd1);
    @(posedge clk);
    #1;
    d2_out_ready = 1'b0;
    @(negedge clk);
    check("d2_valid_end", d2_out_valid, 32'd0);
    check("d2_in_ready_end", d2_in_ready, 32'd1);
    @(posedge clk);
    #1;

    // Sorted input, junk in_valid held during SORT/DRAIN.
    for (int k = 0; k < 8; k++) vec[k] = 8'(k + 1);
    run_batch(1'b1, 1'b0, 7);

    // Reversed input.
    for (int k = 0; k < 8; k++) vec[k] = 8'(8 - k);
    run_batch(1'b0, 1'b0, 49);

    // Duplicates and extremes, with model pinned to the literal result.
    for (int k = 0; k < 8; k++) vec[k] = dup_in[k];
    load_words(8, 1'b1);
    model(be);
    for (int k = 0; k < 8; k++) check("dup_model_literal", exp_q[k], dup_exp[k]);
    wait_sort(cnt);
    check("dup_busy_model", cnt, be);
    check("dup_busy_literal", cnt, 32'd49);
    drain(1'b1);
    @(posedge clk);
    #1;

    // Random batches with random backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) vec[k] = 8'($urandom);
      run_batch(1'b1, 1'b1, -1);
    end

    // Abort after three loaded words, then a clean batch.
    for (int k = 0; k < 8; k++) vec[k] = 8'(100 + k);
    load_words(3, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("in_ready_after_load_abort", in_ready, 32'd1);
    @(posedge clk);
    #1;
    vec = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
    run_batch(1'b0, 1'b1, -1);

    // Abort mid-SORT.
    for (int k = 0; k < 8; k++) vec[k] = 8'(8 - k);
    load_words(8, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("in_ready_after_sort_abort", in_ready, 32'd1);
    check("busy_after_sort_abort", busy, 32'd0);
    vec = '{8'd50, 8'd40, 8'd60, 8'd10, 8'd40, 8'd70, 8'd0, 8'd255};
    run_batch(1'b0, 1'b0, -1);

    // Reset mid-DRAIN drops the batch immediately.
    for (int k = 0; k < 8; k++) vec[k] = 8'($urandom);
    load_words(8, 1'b0);
    model(be);
    wait_sort(cnt);
    check("pre_reset_busy", cnt, be);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_drain_out_valid", out_valid, 32'd0);
    check("reset_drain_in_ready", in_ready, 32'd0);
    check("reset_drain_last", last, 32'd0);
    exp_q.delete();
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset2", in_ready, 32'd1);
    for (int k = 0; k < 8; k++) vec[k] = 8'($urandom);
    run_batch(1'b1, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sort8_ctrl.md
# sort8_ctrl

Sequencing controller that buffers DEPTH unsigned 8-bit words, sorts them ascending using a single shared 8-bit greater-or-equal comparator, and streams them out. It sits between a valid/ready producer and consumer. It also serves as the reference sequencer for the comparator datapath: one compare per clock, with the controller deciding operand selection and swaps.

## Interface
- DEPTH, 8, number of words per batch; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- abort  in  1  synchronous batch cancel; return to LOAD.
- in_valid  in  1  producer word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  8  unsigned input word.
- out_valid  out  1  sorted word available.
- out_ready  in  1  consumer accepts a word.
- out_data  out  8  sorted word, ascending.
- busy  out  1  high while in SORT.
- last  out  1  qualifies the final output beat of a batch.

## Operation
- States: LOAD, SORT, DRAIN. Reset state is LOAD.
- Reset values: in_ready=0 while rst_n low, then 1 in LOAD; out_valid=0; out_data=0; busy=0; last=0; buffer, index, pass and swap flag all cleared.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready stores in_data at mem[wr_idx] and increments wr_idx.
  - When the DEPTH-th word is accepted, go to SORT next cycle.
- SORT (bubble pass):
  - in_ready=0, busy=1.
  - Each cycle compares mem[i+1] >= mem[i] with the ge8_cmp instance.
  - If the compare is false, swap mem[i] and mem[i+1] in the same edge and set swap_flag.
  - i runs 0..DEPTH-2.
  - At i=DEPTH-2, the pass ends. Exit to DRAIN if no swap occurred in that pass (including the final compare) or if pass count has reached DEPTH-1. Otherwise clear swap_flag, set i=0, and increment pass.
  - Equal words are never swapped, so the sort is stable.
- DRAIN:
  - out_valid=1 and out_data=mem[rd_idx].
  - rd_idx advances on out_valid&&out_ready.
  - last=1 when rd_idx=DEPTH-1.
  - The handshake on the last beat returns to LOAD with all indices cleared.
  - out_data and out_valid hold stable while out_ready=0.
- abort:
  - Highest priority over all other events.
  - Next state is LOAD; wr_idx, rd_idx, i, pass and swap_flag are cleared; out_valid drops.
  - Buffer contents are don't-care.
- in_valid outside LOAD is ignored; no data is captured.
- Asynchronous reset mid-SORT or mid-DRAIN takes effect immediately and drops the batch.

## Timing
- Load: minimum DEPTH cycles with in_valid held high.
- Sort: passes×(DEPTH-1) cycles, with passes between 1 and DEPTH-1.
  - DEPTH=8, already sorted input: 7 cycles.
  - DEPTH=8, reversed input: 49 cycles.
- Transitions:
  - First SORT cycle is the cycle after the last LOAD handshake.
  - out_valid rises the cycle after the last SORT compare.
  - in_ready rises the cycle after the final DRAIN handshake.
- Throughput in DRAIN: one word per cycle with out_ready held high.
- The comparator path is combinational (mem mux → ge8_cmp → swap write) within one cycle. There is no pipelining.

## Structure
- Package sort8_pkg holds:
  - state enum (LOAD, SORT, DRAIN);
  - WORD_W=8;
  - index width function clog2(DEPTH).
- Sub-module ge8_cmp: pure combinational 8-bit unsigned a>=b built from 2-bit greater/equal slices. It is instantiated exactly once and is the only comparison resource in the block.
- Buffer is a DEPTH×8 register array, not a RAM, because two entries are read and written per cycle.

## Test plan
- Sorted input: load 1,2,3,4,5,6,7,8 → busy exactly 7 cycles; output 1..8; last only on the 8.
- Reversed input: load 8,7,6,5,4,3,2,1 → busy exactly 49 cycles; output 1..8.
- Duplicates and extremes: load 0xFF,0x00,0x80,0x80,0x7F,0xFF,0x01,0x00 → output 0x00,0x00,0x01,0x7F,0x80,0x80,0xFF,0xFF. Tag the equal words to confirm the original order is kept.
- Backpressure: toggle out_ready 1,0,0,1 randomly during DRAIN → no word dropped or repeated; out_data stable while stalled. Drive in_valid=1 during SORT/DRAIN → no capture.
- Abort and reset:
  - abort after 3 loaded words → next batch of 8 loads cleanly and sorts correctly.
  - abort mid-SORT → in_ready=1 the next cycle.
  - rst_n low mid-DRAIN → out_valid=0 immediately.
- DEPTH=2 instance: load 5,3 → one compare with swap; output 3,5; busy 1 cycle.
